// File: rtl/gray_counter_if.sv
// Control/load and count-output bundle for gray_counter.
// With GRAY_CHK_EN defined, the bundle also carries the sticky o_err flag.
interface gray_counter_if #(
  parameter int N = 8
);
  logic         i_en;
  logic         i_up;
  logic         i_load;
  logic         i_load_gray;
  logic [N-1:0] i_load_val;
  logic [N-1:0] o_bin;
  logic [N-1:0] o_gray;
  logic         o_tc;
`ifdef GRAY_CHK_EN
  logic         o_err;

  modport master (
    output i_en, i_up, i_load, i_load_gray, i_load_val,
    input  o_bin, o_gray, o_tc, o_err
  );
  modport slave (
    input  i_en, i_up, i_load, i_load_gray, i_load_val,
    output o_bin, o_gray, o_tc, o_err
  );
`else
  modport master (
    output i_en, i_up, i_load, i_load_gray, i_load_val,
    input  o_bin, o_gray, o_tc
  );
  modport slave (
    input  i_en, i_up, i_load, i_load_gray, i_load_val,
    output o_bin, o_gray, o_tc
  );
`endif
endinterface

// File: rtl/gray_counter.sv
// N-bit up/down counter with registered binary and Gray outputs, binary/Gray load.
// Define GRAY_CHK_EN to add the sticky one-bit-step checker driving o_err.
module gray_counter #(
  parameter int           N        = 8,
  parameter logic [N-1:0] INIT_BIN = '0
) (
  input  logic           i_clk,
  input  logic           i_rst,
  gray_counter_if.slave  bus
);

  localparam logic [N-1:0] INIT_GRAY = INIT_BIN ^ (INIT_BIN >> 1);
  localparam logic [N-1:0] ALL_ONES  = '1;
  localparam logic [N-1:0] ONE       = {{(N-1){1'b0}}, 1'b1};

  function automatic logic [N-1:0] gray_to_bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int k = N - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

  function automatic logic [N-1:0] bin_to_gray(input logic [N-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [N-1:0] bin_q;
  logic [N-1:0] gray_q;
  logic         tc_q;
  logic [N-1:0] load_bin;
  logic [N-1:0] step_bin;
  logic         wrap;

  always_comb begin
    load_bin = bus.i_load_val;
    if (bus.i_load_gray) begin
      load_bin = gray_to_bin(bus.i_load_val);
    end
    step_bin = bus.i_up ? (bin_q + ONE) : (bin_q - ONE);
    wrap     = bus.i_up ? (bin_q == ALL_ONES) : (bin_q == '0);
  end

  // Gray is always re-derived from the next binary value, so the pair never diverges.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bin_q  <= INIT_BIN;
      gray_q <= INIT_GRAY;
      tc_q   <= 1'b0;
    end else if (bus.i_load) begin
      bin_q  <= load_bin;
      gray_q <= bin_to_gray(load_bin);
      tc_q   <= 1'b0;
    end else if (bus.i_en) begin
      bin_q  <= step_bin;
      gray_q <= bin_to_gray(step_bin);
      tc_q   <= wrap;
    end else begin
      tc_q   <= 1'b0;
    end
  end

  assign bus.o_bin  = bin_q;
  assign bus.o_gray = gray_q;
  assign bus.o_tc   = tc_q;

`ifdef GRAY_CHK_EN
  logic [N-1:0] prev_gray_q;
  logic         step_q;
  logic         err_q;

  function automatic int popcount(input logic [N-1:0] v);
    int cnt;
    cnt = 0;
    for (int k = 0; k < N; k++) begin
      cnt += int'(v[k]);
    end
    return cnt;
  endfunction

  // step_q marks that gray_q was produced by a count step; loads and resets are not checked.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_gray_q <= INIT_GRAY;
      step_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      prev_gray_q <= gray_q;
      step_q      <= bus.i_en & ~bus.i_load;
      if (step_q && (popcount(prev_gray_q ^ gray_q) != 1)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.o_err = err_q;
`endif

endmodule
